// File: rtl/verificador_hash_pkg.sv
// verificador_hash_pkg: shared constants and state encoding for the nonce verifier
package verificador_hash_pkg;
    localparam int BYTE_W = 8;
    localparam int N_BYTES = 16;
    localparam int N_RONDAS_DEF = 32;
    localparam int RONDA_CAMBIO_DEF = 16;
    localparam logic [BYTE_W-1:0] K0 = 8'h99;
    localparam logic [BYTE_W-1:0] K1 = 8'hA1;
    localparam logic [23:0] H_INI_DEF = 24'h0189FE;
    typedef enum logic [2:0] {IDLE, CARGA, RONDA, COMPARA, SIGUIENTE, ENCONTRADO} estado_t;
endpackage

// File: rtl/verificador_hash_ronda.sv
// ronda_hash: one combinational round of the 24-bit micro-hash
module ronda_hash
    import verificador_hash_pkg::*;
#(
    parameter int RW = 5,
    parameter int RONDA_CAMBIO = RONDA_CAMBIO_DEF
) (
    input  logic [RW-1:0]     i,
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic [BYTE_W-1:0] c,
    input  logic [BYTE_W-1:0] w,
    output logic [BYTE_W-1:0] a_sig,
    output logic [BYTE_W-1:0] b_sig,
    output logic [BYTE_W-1:0] c_sig
);
    logic temprana;
    assign temprana = int'(i) <= RONDA_CAMBIO;
    assign a_sig = b ^ c;
    assign b_sig = {c[3:0], c[7:4]};
    assign c_sig = (temprana ? a ^ b : a ^ c) + (temprana ? K0 : K1) + w;
endmodule

// File: rtl/verificador_hash.sv
// verificador_hash: consumes nonces, runs the iterative micro-hash and flags a nonce under target
module verificador_hash
    import verificador_hash_pkg::*;
#(
    parameter int N_RONDAS = N_RONDAS_DEF,
    parameter int RONDA_CAMBIO = RONDA_CAMBIO_DEF,
    parameter logic [23:0] H_INI = H_INI_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inicio,
    input  logic [95:0] bloque,
    input  logic [7:0]  objetivo,
    input  logic        nonce_valido,
    input  logic [31:0] nonce,
    output logic        siguiente,
    output logic        ocupado,
    output logic        terminado,
    output logic [31:0] nonce_encontrado,
    output logic [23:0] hash
);
    localparam int RW = $clog2(N_RONDAS);
    estado_t estado, estado_sig;
    logic [BYTE_W-1:0] ventana [N_BYTES];
    logic [BYTE_W-1:0] a, b, c, a_sig, b_sig, c_sig, h0, h1, h2;
    logic [RW-1:0] ronda;
    logic [31:0] nonce_cap;
    logic [127:0] mensaje;
    logic ultima, hallado;

    ronda_hash #(.RW(RW), .RONDA_CAMBIO(RONDA_CAMBIO)) u_ronda (
        .i(ronda), .a(a), .b(b), .c(c), .w(ventana[0]),
        .a_sig(a_sig), .b_sig(b_sig), .c_sig(c_sig)
    );

    assign mensaje = {bloque, nonce};
    assign h0 = H_INI[23:16] + a;
    assign h1 = H_INI[15:8] + b;
    assign h2 = H_INI[7:0] + c;
    assign hallado = h0 < objetivo && h1 < objetivo;
    assign ultima = ronda == RW'(N_RONDAS - 1);

    always_comb begin
        estado_sig = estado;
        siguiente = estado == SIGUIENTE;
        ocupado = estado inside {CARGA, RONDA, COMPARA};
        case (estado)
            IDLE:      estado_sig = inicio && nonce_valido ? CARGA : IDLE;
            CARGA:     estado_sig = inicio ? RONDA : IDLE;
            RONDA:     estado_sig = !inicio ? IDLE : ultima ? COMPARA : RONDA;
            COMPARA:   estado_sig = !inicio ? IDLE : hallado ? ENCONTRADO : SIGUIENTE;
            SIGUIENTE: estado_sig = IDLE;
            default:   estado_sig = estado;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado <= IDLE;
            a <= '0;
            b <= '0;
            c <= '0;
            ronda <= '0;
            nonce_cap <= '0;
            hash <= '0;
            terminado <= 1'b0;
            nonce_encontrado <= '0;
            for (int k = 0; k < N_BYTES; k++) ventana[k] <= '0;
        end else begin
            estado <= estado_sig;
            case (estado)
                IDLE: if (estado_sig == CARGA) begin
                    nonce_cap <= nonce;
                    for (int k = 0; k < N_BYTES; k++) ventana[k] <= mensaje[127-8*k -: 8];
                end
                CARGA: begin
                    {a, b, c} <= H_INI;
                    ronda <= '0;
                end
                RONDA: begin
                    a <= a_sig;
                    b <= b_sig;
                    c <= c_sig;
                    ronda <= ronda + 1'b1;
                    for (int k = 0; k < N_BYTES - 1; k++) ventana[k] <= ventana[k+1];
                    ventana[N_BYTES-1] <= ventana[13] | (ventana[7] ^ ventana[2]);
                end
                COMPARA: if (inicio) begin
                    hash <= {h0, h1, h2};
                    if (hallado) begin
                        terminado <= 1'b1;
                        nonce_encontrado <= nonce_cap;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_verificador_hash.sv
// tb_verificador_hash: scoreboard bench for the nonce verifier
module tb_verificador_hash;
    logic clk = 0, reset = 1, inicio = 0, nonce_valido = 0;
    logic [95:0] bloque = '0;
    logic [7:0] objetivo = '0;
    logic [31:0] nonce = '0;
    logic siguiente, ocupado, terminado;
    logic [31:0] nonce_encontrado;
    logic [23:0] hash;

    typedef struct packed {logic [23:0] hash; logic hallado; logic [31:0] nonce;} esperado_t;
    esperado_t cola [$];
    esperado_t e;
    int n_cmp = 0, n_err = 0, edge_cnt = 0, t_acc = 0, n_sig = 0;
    logic ocup_prev = 0, term_prev = 0;

    verificador_hash dut (
        .clk(clk), .reset(reset), .inicio(inicio), .bloque(bloque), .objetivo(objetivo),
        .nonce_valido(nonce_valido), .nonce(nonce), .siguiente(siguiente), .ocupado(ocupado),
        .terminado(terminado), .nonce_encontrado(nonce_encontrado), .hash(hash)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt++;

    task automatic check(string nombre, logic [31:0] actual, logic [31:0] req);
        n_cmp++;
        if (actual !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nombre, actual, req);
        end
    endtask

    function automatic logic [23:0] modelo(logic [95:0] blk, logic [31:0] nn);
        logic [7:0] w [32];
        logic [127:0] m;
        logic [7:0] a, b, c, x, k;
        m = {blk, nn};
        for (int j = 0; j < 16; j++) w[j] = m[127-8*j -: 8];
        for (int j = 16; j < 32; j++) w[j] = w[j-3] | (w[j-9] ^ w[j-14]);
        a = 8'h01; b = 8'h89; c = 8'hFE;
        for (int i = 0; i < 32; i++) begin
            x = (i <= 16) ? a ^ b : a ^ c;
            k = (i <= 16) ? 8'h99 : 8'hA1;
            {a, b, c} = {b ^ c, c[3:0], c[7:4], 8'(x + k + w[i])};
        end
        return {8'(8'h01 + a), 8'(8'h89 + b), 8'(8'hFE + c)};
    endfunction

    function automatic logic gana(logic [23:0] h, logic [7:0] o);
        return h[23:16] < o && h[15:8] < o;
    endfunction

    always @(negedge clk) begin
        if (ocupado && !ocup_prev) t_acc = edge_cnt;
        if (siguiente) n_sig++;
        if (siguiente || (terminado && !term_prev)) begin
            if (cola.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected result event: siguiente=%b terminado=%b hash=%h", siguiente, terminado, hash);
            end else begin
                e = cola.pop_front();
                check("hash", 32'(hash), 32'(e.hash));
                check("terminado", 32'(terminado), 32'(e.hallado));
                check("siguiente", 32'(siguiente), 32'(!e.hallado));
                check("latency", edge_cnt - t_acc, 34);
                if (e.hallado) check("nonce_encontrado", nonce_encontrado, e.nonce);
            end
        end
        ocup_prev = ocupado;
        term_prev = terminado;
    end

    task automatic ciclos(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic esperar_acepta(output logic ok);
        ok = 0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            ok = ocupado;
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout waiting for nonce acceptance: ocupado=%b expected 1", ocupado);
        end
    endtask

    task automatic esperar_fin(output logic ok);
        ok = 0;
        for (int i = 0; i < 80 && !ok; i++) begin
            @(negedge clk);
            ok = siguiente || terminado;
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout waiting for result: siguiente=%b terminado=%b expected a pulse", siguiente, terminado);
        end
    endtask

    task automatic check_ceros(string etapa);
        check({etapa, " siguiente"}, 32'(siguiente), 0);
        check({etapa, " ocupado"}, 32'(ocupado), 0);
        check({etapa, " terminado"}, 32'(terminado), 0);
        check({etapa, " nonce_encontrado"}, nonce_encontrado, 0);
        check({etapa, " hash"}, 32'(hash), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic ok, f, encontrado;
        logic [23:0] h, ultimo_hash;
        int sig_antes, found_n;
        ultimo_hash = '0;
        ciclos(3);
        check_ceros("reset");
        reset = 0;
        ciclos(10);
        check_ceros("idle");
        check("idle siguiente pulses", n_sig, 0);

        h = modelo(96'h0, 32'h0);
        cola.push_back({h, 1'b0, 32'h0});
        nonce_valido = 1;
        inicio = 1;
        esperar_fin(ok);
        inicio = 0;
        ultimo_hash = h;
        ciclos(2);
        check("zero vector terminado", 32'(terminado), 0);

        bloque = 96'h0123_4567_89AB_CDEF_0123_4567;
        objetivo = 8'h40;
        nonce_valido = 0;
        inicio = 1;
        ciclos(6);
        check("nonce_valido low waits", 32'(ocupado), 0);
        nonce_valido = 1;
        encontrado = 0;
        found_n = 0;
        for (int n = 0; n < 256 && !encontrado; n++) begin
            h = modelo(bloque, 32'(n));
            f = gana(h, 8'h40);
            cola.push_back({h, f, 32'(n)});
            nonce = 32'(n);
            esperar_acepta(ok);
            if (!ok) break;
            nonce = ~32'(n);
            esperar_fin(ok);
            if (!ok) break;
            ultimo_hash = h;
            encontrado = f;
            found_n = n;
        end
        sig_antes = n_sig;
        ciclos(40);
        check("sweep terminado", 32'(terminado), 32'(encontrado));
        check("sweep nonce_encontrado", nonce_encontrado, encontrado ? 32'(found_n) : 32'h0);
        check("sweep generator stopped", n_sig, sig_antes);
        check("sweep hash held", 32'(hash), 32'(ultimo_hash));
        inicio = 0;
        reset = 1;
        ciclos(1);
        check_ceros("reset in ENCONTRADO");
        reset = 0;
        ultimo_hash = '0;

        bloque = '1;
        nonce = '1;
        objetivo = 8'hFF;
        h = modelo(bloque, nonce);
        f = h[23:16] != 8'hFF && h[15:8] != 8'hFF;
        cola.push_back({h, f, 32'hFFFF_FFFF});
        inicio = 1;
        esperar_fin(ok);
        inicio = 0;
        ultimo_hash = h;
        ciclos(2);
        if (f) begin
            reset = 1;
            ciclos(1);
            reset = 0;
            ultimo_hash = '0;
        end

        objetivo = 8'h00;
        bloque = 96'hDEAD_BEEF_CAFE_BABE_1234_5678;
        nonce = 32'h0BAD_F00D;
        inicio = 1;
        esperar_acepta(ok);
        ciclos(11);
        inicio = 0;
        sig_antes = n_sig;
        ciclos(1);
        check("abort ocupado", 32'(ocupado), 0);
        check("abort hash", 32'(hash), 32'(ultimo_hash));
        ciclos(40);
        check("abort no siguiente", n_sig, sig_antes);
        check("abort no terminado", 32'(terminado), 0);
        nonce = 32'h1357_9BDF;
        h = modelo(bloque, nonce);
        cola.push_back({h, 1'b0, nonce});
        inicio = 1;
        esperar_fin(ok);
        inicio = 0;
        ultimo_hash = h;
        ciclos(2);

        nonce = 32'h2468_ACE0;
        inicio = 1;
        esperar_acepta(ok);
        ciclos(15);
        reset = 1;
        inicio = 0;
        ciclos(1);
        check_ceros("reset in RONDA");
        reset = 0;
        ciclos(5);
        check("post reset ocupado", 32'(ocupado), 0);
        check("scoreboard drained", cola.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
